// File: rtl/dp_sink_pkg.sv
// Shared definitions for the DisplayPort sink AUX responder: reply codes, FSM
// states, DPCD memory map and the span-checking helpers.
package dp_sink_pkg;

    localparam logic [1:0] ACK_CODE_ACK   = 2'b00;
    localparam logic [1:0] ACK_CODE_NACK  = 2'b01;
    localparam logic [1:0] ACK_CODE_DEFER = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_COLLECT,
        ST_WAIT,
        ST_REPLY_ACK,
        ST_REPLY_DATA
    } state_e;

    localparam logic [19:0] CAP_BASE  = 20'h00000;
    localparam logic [19:0] CAP_SIZE  = 20'd16;
    localparam logic [19:0] RW_BASE   = 20'h00100;
    localparam logic [19:0] RW_SIZE   = 20'd16;
    localparam logic [19:0] STAT_BASE = 20'h00200;
    localparam logic [19:0] STAT_SIZE = 20'd8;

    // Capability bytes, byte k at bits 8k+7:8k (0x00=0x12, 0x01=0x0A, 0x02=0x84, rest 0x00)
    localparam logic [127:0] CAP_ROM = {104'h0, 8'h84, 8'h0A, 8'h12};

    function automatic logic in_region(input logic [19:0] a, input logic [19:0] base,
                                       input logic [19:0] size);
        return (a >= base) && (a < base + size);
    endfunction

    function automatic logic addr_mapped(input logic [19:0] a);
        return in_region(a, CAP_BASE, CAP_SIZE) || in_region(a, RW_BASE, RW_SIZE) ||
               in_region(a, STAT_BASE, STAT_SIZE);
    endfunction

    // Returns {every byte mapped, every byte writable} for a span of len+1 bytes.
    function automatic logic [1:0] span_check(input logic [19:0] base, input logic [3:0] len);
        logic        mapped;
        logic        rw;
        logic [19:0] a;
        mapped = 1'b1;
        rw     = 1'b1;
        a      = base;
        for (int i = 0; i < 16; i++) begin
            if (4'(i) <= len) begin
                a = base + 20'(i);
                if (!addr_mapped(a)) mapped = 1'b0;
                if (!in_region(a, RW_BASE, RW_SIZE)) rw = 1'b0;
            end
        end
        return {mapped, rw};
    endfunction

endpackage

// File: rtl/dp_sink_aux_responder_dpcd_regfile.sv
// DPCD storage: capability ROM, 16-byte R/W array and live status mux behind
// one combinational read port and one atomic 16-byte write port.
module dp_sink_dpcd_regfile
    import dp_sink_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [19:0]      rd_addr,
    output logic [7:0]       rd_data,
    input  logic [63:0]      sink_status,
    input  logic             wr_en,
    input  logic [3:0]       wr_offset,
    input  logic [3:0]       wr_len,
    input  logic [15:0][7:0] wr_buf
);

    logic [15:0][7:0] rw_q;
    logic [15:0][7:0] rw_d;

    always_comb begin
        rw_d = rw_q;
        if (wr_en) begin
            for (int i = 0; i < 16; i++) begin
                if (4'(i) <= wr_len) rw_d[wr_offset + 4'(i)] = wr_buf[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rw_q <= '0;
        else       rw_q <= rw_d;
    end

    always_comb begin
        rd_data = 8'h00;
        if (in_region(rd_addr, CAP_BASE, CAP_SIZE))
            rd_data = CAP_ROM[{rd_addr[3:0], 3'b000} +: 8];
        else if (in_region(rd_addr, RW_BASE, RW_SIZE))
            rd_data = rw_q[rd_addr[3:0]];
        else if (in_region(rd_addr, STAT_BASE, STAT_SIZE))
            rd_data = sink_status[{rd_addr[2:0], 3'b000} +: 8];
    end

endmodule

// File: rtl/dp_sink_aux_responder.sv
// AUX request responder: collects a native read/write request, waits the
// turnaround time, replies ACK/NACK/DEFER and streams read data.
//
//  state         | meaning
//  IDLE          | waiting for a request byte
//  WR_COLLECT    | receiving remaining write bytes
//  WAIT          | turnaround down-count before the reply
//  REPLY_ACK     | one-cycle reply strobe; ACKed writes commit here
//  REPLY_DATA    | streaming LEN+1 read bytes
module dp_sink_aux_responder
    import dp_sink_pkg::*;
#(
    parameter int RPL_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        REQ_Transaction_VLD,
    input  logic [1:0]  REQ_CMD,
    input  logic [19:0] REQ_Address,
    input  logic [7:0]  REQ_LEN,
    input  logic [7:0]  REQ_Data,
    input  logic        DEFER_REQ,
    input  logic [63:0] SINK_STATUS,
    output logic [1:0]  RPL_ACK,
    output logic        RPL_ACK_VLD,
    output logic [7:0]  RPL_Data,
    output logic        RPL_Data_VLD,
    output logic        RPL_NATIVE_I2C,
    output logic        BUSY
);

    state_e           state_q, state_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [19:0]      addr_q, addr_d;
    logic [7:0]       len_q, len_d;
    logic             defer_q, defer_d;
    logic             early_q, early_d;
    logic [8:0]       byte_cnt_q, byte_cnt_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic [15:0][7:0] buf_q, buf_d;
    logic [1:0]       ack_q, ack_d;
    logic             ack_vld_q, ack_vld_d;
    logic [7:0]       data_q, data_d;
    logic             data_vld_q, data_vld_d;
    logic             native_q, native_d;
    logic             busy_q, busy_d;

    logic [1:0]  span;
    logic        addr_ovf;
    logic [1:0]  reply_code;
    logic [19:0] rd_addr;
    logic [7:0]  rd_data;
    logic        wr_en;

    always_comb begin
        span     = span_check(addr_q, len_q[3:0]);
        addr_ovf = ({1'b0, addr_q} + {13'd0, len_q}) > 21'hFFFFF;
        if (defer_q)
            reply_code = ACK_CODE_DEFER;
        else if (!cmd_q[1] || (len_q > 8'd15) || early_q || addr_ovf || !span[1])
            reply_code = ACK_CODE_NACK;
        else if (!cmd_q[0] && !span[0])
            reply_code = ACK_CODE_NACK;
        else
            reply_code = ACK_CODE_ACK;
    end

    assign rd_addr = addr_q + {12'd0, byte_cnt_q[7:0]};
    assign wr_en   = (state_q == ST_REPLY_ACK) && (ack_q == ACK_CODE_ACK) && !cmd_q[0];

    dp_sink_dpcd_regfile u_regfile (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .sink_status (SINK_STATUS),
        .wr_en       (wr_en),
        .wr_offset   (addr_q[3:0]),
        .wr_len      (len_q[3:0]),
        .wr_buf      (buf_q)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        len_d      = len_q;
        defer_d    = defer_q;
        early_d    = early_q;
        byte_cnt_d = byte_cnt_q;
        wait_cnt_d = wait_cnt_q;
        buf_d      = buf_q;
        ack_d      = ack_q;
        native_d   = native_q;
        ack_vld_d  = 1'b0;
        data_d     = 8'h00;
        data_vld_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (REQ_Transaction_VLD) begin
                    cmd_d      = REQ_CMD;
                    addr_d     = REQ_Address;
                    len_d      = REQ_LEN;
                    defer_d    = DEFER_REQ;
                    early_d    = 1'b0;
                    buf_d[0]   = REQ_Data;
                    byte_cnt_d = 9'd1;
                    wait_cnt_d = 4'(RPL_WAIT - 1);
                    if (!REQ_CMD[0] && (REQ_LEN != 8'd0)) state_d = ST_WR_COLLECT;
                    else                                  state_d = ST_WAIT;
                end
            end
            ST_WR_COLLECT: begin
                if (REQ_Transaction_VLD) begin
                    // Bytes past the 16-byte buffer are counted only; LEN>15 is NACKed anyway.
                    if (byte_cnt_q < 9'd16) buf_d[byte_cnt_q[3:0]] = REQ_Data;
                    byte_cnt_d = byte_cnt_q + 9'd1;
                    if (byte_cnt_q == {1'b0, len_q}) state_d = ST_WAIT;
                end else begin
                    early_d = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d    = ST_REPLY_ACK;
                    ack_d      = reply_code;
                    ack_vld_d  = 1'b1;
                    native_d   = cmd_q[1];
                    byte_cnt_d = 9'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_REPLY_ACK: begin
                if (cmd_q[0] && (ack_q == ACK_CODE_ACK)) begin
                    state_d    = ST_REPLY_DATA;
                    data_d     = rd_data;
                    data_vld_d = 1'b1;
                    byte_cnt_d = 9'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REPLY_DATA: begin
                if (byte_cnt_q <= {1'b0, len_q}) begin
                    data_d     = rd_data;
                    data_vld_d = 1'b1;
                    byte_cnt_d = byte_cnt_q + 9'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            defer_q    <= 1'b0;
            early_q    <= 1'b0;
            byte_cnt_q <= '0;
            wait_cnt_q <= '0;
            buf_q      <= '0;
            ack_q      <= ACK_CODE_ACK;
            ack_vld_q  <= 1'b0;
            data_q     <= 8'h00;
            data_vld_q <= 1'b0;
            native_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            defer_q    <= defer_d;
            early_q    <= early_d;
            byte_cnt_q <= byte_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            buf_q      <= buf_d;
            ack_q      <= ack_d;
            ack_vld_q  <= ack_vld_d;
            data_q     <= data_d;
            data_vld_q <= data_vld_d;
            native_q   <= native_d;
            busy_q     <= busy_d;
        end
    end

    assign RPL_ACK        = ack_q;
    assign RPL_ACK_VLD    = ack_vld_q;
    assign RPL_Data       = data_q;
    assign RPL_Data_VLD   = data_vld_q;
    assign RPL_NATIVE_I2C = native_q;
    assign BUSY           = busy_q;

endmodule

// File: tb/tb_dp_sink_aux_responder.sv
// Directed bench for dp_sink_aux_responder with hand-computed replies.
module tb_dp_sink_aux_responder;

    localparam int RPL_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        REQ_Transaction_VLD;
    logic [1:0]  REQ_CMD;
    logic [19:0] REQ_Address;
    logic [7:0]  REQ_LEN;
    logic [7:0]  REQ_Data;
    logic        DEFER_REQ;
    logic [63:0] SINK_STATUS;
    logic [1:0]  RPL_ACK;
    logic        RPL_ACK_VLD;
    logic [7:0]  RPL_Data;
    logic        RPL_Data_VLD;
    logic        RPL_NATIVE_I2C;
    logic        BUSY;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] rx [32];
    int         rx_n;
    int         last_lat;

    dp_sink_aux_responder #(.RPL_WAIT(RPL_WAIT)) dut (
        .clk                 (clk),
        .reset               (reset),
        .REQ_Transaction_VLD (REQ_Transaction_VLD),
        .REQ_CMD             (REQ_CMD),
        .REQ_Address         (REQ_Address),
        .REQ_LEN             (REQ_LEN),
        .REQ_Data            (REQ_Data),
        .DEFER_REQ           (DEFER_REQ),
        .SINK_STATUS         (SINK_STATUS),
        .RPL_ACK             (RPL_ACK),
        .RPL_ACK_VLD         (RPL_ACK_VLD),
        .RPL_Data            (RPL_Data),
        .RPL_Data_VLD        (RPL_Data_VLD),
        .RPL_NATIVE_I2C      (RPL_NATIVE_I2C),
        .BUSY                (BUSY)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives nb request bytes on consecutive cycles; byte i of d is d[8i+7:8i].
    task automatic send(input logic [1:0] cmd, input logic [19:0] addr, input logic [7:0] len,
                        input logic dfr, input int nb, input logic [255:0] d);
        REQ_CMD     = cmd;
        REQ_Address = addr;
        REQ_LEN     = len;
        DEFER_REQ   = dfr;
        for (int i = 0; i < nb; i++) begin
            REQ_Transaction_VLD = 1'b1;
            REQ_Data            = d[8*i +: 8];
            step();
        end
        REQ_Transaction_VLD = 1'b0;
        REQ_Data            = 8'h00;
        DEFER_REQ           = 1'b0;
    endtask

    task automatic get_reply(input string tag, output logic [1:0] ack, output logic nat);
        last_lat = 0;
        while (!RPL_ACK_VLD && last_lat < 64) begin
            step();
            last_lat++;
        end
        check({tag, " ack_vld_seen"}, RPL_ACK_VLD, 1);
        ack = RPL_ACK;
        nat = RPL_NATIVE_I2C;
        check({tag, " data_zero_at_ack"}, {RPL_Data_VLD, RPL_Data}, 0);
        step();
        rx_n = 0;
        while (RPL_Data_VLD && rx_n < 32) begin
            rx[rx_n] = RPL_Data;
            rx_n++;
            step();
        end
        check({tag, " idle_after"}, {BUSY, RPL_Data}, 0);
    endtask

    task automatic xfer(input string tag, input logic [1:0] cmd, input logic [19:0] addr,
                        input logic [7:0] len, input logic dfr, input int nb,
                        input logic [255:0] d, input logic [1:0] exp_ack, input int exp_n,
                        input logic [255:0] exp_d);
        logic [1:0] ack;
        logic       nat;
        send(cmd, addr, len, dfr, nb, d);
        get_reply(tag, ack, nat);
        check({tag, " ack"}, ack, exp_ack);
        check({tag, " native"}, nat, cmd[1]);
        check({tag, " n_data"}, rx_n, exp_n);
        for (int i = 0; i < exp_n && i < rx_n; i++)
            check($sformatf("%s byte%0d", tag, i), rx[i], exp_d[8*i +: 8]);
    endtask

    initial begin
        logic saw_ack;
        reset               = 1'b1;
        REQ_Transaction_VLD = 1'b0;
        REQ_CMD             = 2'b00;
        REQ_Address         = 20'h0;
        REQ_LEN             = 8'h0;
        REQ_Data            = 8'h0;
        DEFER_REQ           = 1'b0;
        SINK_STATUS         = 64'h0807060504030201;
        repeat (3) step();
        check("reset outputs", {RPL_ACK, RPL_ACK_VLD, RPL_Data, RPL_Data_VLD, RPL_NATIVE_I2C, BUSY}, 0);
        reset = 1'b0;

        // Request presented on the very first cycle out of reset.
        xfer("cap_read", 2'b11, 20'h00000, 8'd2, 1'b0, 1, 0, 2'b00, 3, {8'h84, 8'h0A, 8'h12});
        check("cap_read ack_latency", last_lat + 1, RPL_WAIT + 1);

        xfer("rw_write", 2'b10, 20'h00100, 8'd1, 1'b0, 2, {8'h82, 8'h0A}, 2'b00, 0, 0);
        xfer("rw_read", 2'b11, 20'h00100, 8'd1, 1'b0, 1, 0, 2'b00, 2, {8'h82, 8'h0A});

        xfer("cap_write", 2'b10, 20'h0000E, 8'd3, 1'b0, 4, 32'h44332211, 2'b01, 0, 0);
        xfer("rw_read2", 2'b11, 20'h00100, 8'd1, 1'b0, 1, 0, 2'b00, 2, {8'h82, 8'h0A});

        xfer("defer_read", 2'b11, 20'h00101, 8'd0, 1'b1, 1, 0, 2'b10, 0, 0);
        xfer("i2c_read", 2'b01, 20'h00000, 8'd0, 1'b0, 1, 0, 2'b01, 0, 0);

        xfer("early_drop", 2'b10, 20'h00100, 8'd3, 1'b0, 2, {8'h22, 8'h11}, 2'b01, 0, 0);
        xfer("rw_read3", 2'b11, 20'h00100, 8'd1, 1'b0, 1, 0, 2'b00, 2, {8'h82, 8'h0A});

        xfer("edge_write", 2'b10, 20'h0010E, 8'd1, 1'b0, 2, {8'h5A, 8'hA5}, 2'b00, 0, 0);
        xfer("edge_read", 2'b11, 20'h0010E, 8'd1, 1'b0, 1, 0, 2'b00, 2, {8'h5A, 8'hA5});
        xfer("past_rw_write", 2'b10, 20'h0010F, 8'd1, 1'b0, 2, {8'h66, 8'h77}, 2'b01, 0, 0);
        xfer("gap_read", 2'b11, 20'h0000E, 8'd3, 1'b0, 1, 0, 2'b01, 0, 0);
        xfer("len16_read", 2'b11, 20'h00100, 8'd16, 1'b0, 1, 0, 2'b01, 0, 0);

        // Reset while in WAIT: no reply, pending write dropped, R/W region cleared.
        send(2'b10, 20'h00102, 8'd0, 1'b0, 1, 8'h77);
        step();
        reset = 1'b1;
        step();
        check("mid_reset outputs", {RPL_ACK_VLD, RPL_Data_VLD, BUSY}, 0);
        step();
        reset   = 1'b0;
        saw_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            saw_ack |= RPL_ACK_VLD;
            step();
        end
        check("mid_reset no_ack", saw_ack, 0);
        check("mid_reset busy", BUSY, 0);
        xfer("post_reset_read", 2'b11, 20'h00100, 8'd3, 1'b0, 1, 0, 2'b00, 4, 0);

        xfer("long_write", 2'b10, 20'h00100, 8'd16, 1'b0, 17, {136{1'b1}}, 2'b01, 0, 0);
        xfer("post_long_read", 2'b11, 20'h00100, 8'd1, 1'b0, 1, 0, 2'b00, 2, 0);

        xfer("status_read", 2'b11, 20'h00200, 8'd7, 1'b0, 1, 0, 2'b00, 8, 64'h0807060504030201);
        xfer("wrap_read", 2'b11, 20'hFFFFE, 8'd3, 1'b0, 1, 0, 2'b01, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dp_sink_aux_responder.md
DP_SINK_AUX_RESPONDER -- requirements
Module: dp_sink_aux_responder

Interface
REQ-001 SHALL have parameter RPL_WAIT, default 4, meaning the turnaround cycles between request end and reply start (range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port REQ_Transaction_VLD, input, 1, request byte valid.
REQ-005 SHALL have port REQ_CMD, input, 2, bit1 = 1 for native and 0 for I2C; bit0 = 1 for read and 0 for write.
REQ-006 SHALL have port REQ_Address, input, 20, the DPCD start address.
REQ-007 SHALL have port REQ_LEN, input, 8, the byte count minus 1.
REQ-008 SHALL have port REQ_Data, input, 8, the write data byte.
REQ-009 SHALL have port DEFER_REQ, input, 1, which forces a DEFER reply when sampled high on the request first cycle.
REQ-010 SHALL have port SINK_STATUS, input, 64, the live status bytes for 0x00200–0x00207 (byte k = bits 8k+7:8k).
REQ-011 SHALL have port RPL_ACK, output, 2, the reply code: 00 ACK, 01 NACK, 10 DEFER.
REQ-012 SHALL have port RPL_ACK_VLD, output, 1, a one-cycle reply-status strobe.
REQ-013 SHALL have port RPL_Data, output, 8, the read data byte.
REQ-014 SHALL have port RPL_Data_VLD, output, 1, read data valid.
REQ-015 SHALL have port RPL_NATIVE_I2C, output, 1, an echo of the latched REQ_CMD[1], valid with RPL_ACK_VLD.
REQ-016 SHALL have port BUSY, output, 1, high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, WR_COLLECT, WAIT, REPLY_ACK and REPLY_DATA.
REQ-018 In IDLE with VLD high, SHALL latch CMD, Address, LEN and DEFER_REQ, and treat REQ_Data as write byte 0.
REQ-019 Transitions from IDLE with VLD high:
- write with LEN>0 -> WR_COLLECT;
- any other request -> WAIT.
REQ-020 WR_COLLECT SHALL accept one byte per cycle while VLD is high, until LEN+1 bytes total, then -> WAIT.
REQ-021 If VLD drops early in WR_COLLECT, SHALL -> WAIT with NACK forced.
REQ-022 Bytes beyond index 15 SHALL be counted but not stored.
REQ-023 WAIT SHALL last exactly RPL_WAIT cycles, then -> REPLY_ACK.
REQ-024 Reply code decision, in priority order:
- DEFER if the latched DEFER_REQ is high;
- else NACK if CMD[1]=0 (I2C), LEN>15, early VLD drop, a 21-bit Address+LEN beyond 0xFFFFF, or any byte in the span unmapped;
- else NACK for a write if any byte is outside the R/W region;
- else ACK.
REQ-025 REPLY_ACK SHALL last one cycle, with RPL_ACK_VLD=1 and RPL_ACK and RPL_NATIVE_I2C valid.
REQ-026 After REPLY_ACK, an ACKed read SHALL -> REPLY_DATA; every other reply SHALL -> IDLE.
REQ-027 REPLY_DATA SHALL drive RPL_Data_VLD=1 for exactly LEN+1 consecutive cycles, with bytes from ascending addresses, then -> IDLE.
REQ-028 An ACKed write SHALL commit all buffered bytes atomically in the REPLY_ACK cycle.
REQ-029 NACKed or DEFERred writes SHALL modify nothing.
REQ-030 Memory map:
- 0x00000–0x0000F: read-only capability bytes from package constants;
- 0x00100–0x0010F: R/W, 16 bytes;
- 0x00200–0x00207: read-only, SINK_STATUS sampled at each data cycle;
- all other addresses unmapped.
REQ-031 A read span crossing region boundaries SHALL be ACKed only if every byte is mapped; a span into a gap SHALL be NACKed.
REQ-032 VLD while BUSY and not in WR_COLLECT SHALL be ignored, with no state change.
REQ-033 RPL_Data SHALL be 0x00 whenever RPL_Data_VLD=0.

Reset
REQ-034 Reset SHALL take priority over all other logic.
REQ-035 Reset SHALL put the FSM in IDLE and zero the counters and buffer.
REQ-036 Reset SHALL set RPL_ACK=00, RPL_ACK_VLD=0, RPL_Data=0, RPL_Data_VLD=0, RPL_NATIVE_I2C=0 and BUSY=0.
REQ-037 Reset SHALL set all R/W bytes to 0x00.
REQ-038 Reset mid-transaction SHALL abort with no commit and no reply strobe.
REQ-039 The first request SHALL be accepted on the first cycle after reset deasserts.

Structure
REQ-040 Package dp_sink_pkg SHALL hold:
- the reply-code constants;
- the FSM state enum;
- the region base and size constants;
- the 16 capability byte constants (0x00=0x12, 0x01=0x0A, 0x02=0x84, 0x0E=0x00, others 0x00).
REQ-041 Sub-module dp_sink_dpcd_regfile SHALL hold the R/W array, capability ROM and status mux, with one read port and a 16-byte atomic write port.

Verification
REQ-042 Native read, addr 0x00000, LEN=2 -> ACK_VLD 5 cycles after VLD (RPL_WAIT=4), then Data 0x12, 0x0A, 0x84 on 3 consecutive cycles.
REQ-043 Native write 0x00100, LEN=1, data 0x0A, 0x82; then read the same span -> ACK, then 0x0A, 0x82.
REQ-044 Write 0x0000E LEN=3 -> NACK, and a following read of 0x00100 is unchanged.
REQ-045 Read 0x00101 with DEFER_REQ=1 -> DEFER, no Data_VLD; I2C read (CMD=01) -> NACK with RPL_NATIVE_I2C=0.
REQ-046 Write LEN=3 with VLD dropped after 2 bytes -> NACK, region unchanged.
REQ-047 Reset asserted in WAIT -> no ACK_VLD, and the R/W region reads 0x00.
REQ-048 Read 0x00200 LEN=7 with SINK_STATUS=0x0807060504030201 -> ACK, then 0x01..0x08.
REQ-049 Read 0xFFFFE LEN=3 -> NACK (address wrap).
